cache_assoc_controller: RTL and testbench

//  Parametrised N-way set-associative cache controller with an internal tag/valid/dirty/LRU store.

---
 rtl/cache_assoc_controller.sv | 187 ++++++++++++++++++
 tb/tb_cache_assoc_controller.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_assoc_controller.sv
// Purpose: N-way set-associative cache controller that holds tag/valid/dirty/LRU state and drives an external data array and RAM.
// Latency: a read hit acks 2 cycles after the request is sampled, a write-back write hit acks after 3, and a miss waits for the RAM.
// Backpressure: the CPU holds its request until OUT_ACK, and RAM strobes stay high until IN_RAM_ACK with no timeout.
// Ports: IN_CLK/IN_RESET (sync, active-high); CPU request IN_CPU_RD/WR/ADDR; RAM completion IN_RAM_ACK;
//        OUT_ACK/OUT_HIT complete the request; OUT_WAY/OUT_DATA_LOAD/OUT_DATA_WR steer the data array;
//        OUT_RAM_RD/WR/ADDR/SRC run the RAM transaction (SRC 1 = data array, 0 = CPU data).
module cache_assoc_controller #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INDEX_WIDTH = 4,
    parameter int WAYS        = 2,
    parameter int WRITE_BACK  = 1,
    localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                  IN_CLK,
    input  logic                  IN_RESET,
    input  logic                  IN_CPU_RD,
    input  logic                  IN_CPU_WR,
    input  logic [ADDR_WIDTH-1:0] IN_CPU_ADDR,
    input  logic                  IN_RAM_ACK,
    output logic                  OUT_ACK,
    output logic                  OUT_HIT,
    output logic [WAY_W-1:0]      OUT_WAY,
    output logic                  OUT_DATA_LOAD,
    output logic                  OUT_DATA_WR,
    output logic                  OUT_RAM_RD,
    output logic                  OUT_RAM_WR,
    output logic [ADDR_WIDTH-1:0] OUT_RAM_ADDR,
    output logic                  OUT_RAM_SRC
);
    localparam int SETS  = 1 << INDEX_WIDTH;
    localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH;
    localparam logic [WAY_W-1:0] OLDEST = WAY_W'(WAYS - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, REFILL, WR_HIT, WT_WR, ACK} state_t;

    state_t           state_q, state_d;
    logic             is_wr_q;
    logic             hit_q;
    logic [WAY_W-1:0] way_q;

    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    logic [WAY_W-1:0] age_q   [SETS][WAYS];

    logic [INDEX_WIDTH-1:0] idx;
    logic [TAG_W-1:0]       req_tag;
    assign idx     = IN_CPU_ADDR[INDEX_WIDTH-1:0];
    assign req_tag = IN_CPU_ADDR[ADDR_WIDTH-1:INDEX_WIDTH];

    // Tag compare and victim choice for the addressed set.
    logic             lk_hit, lk_free;
    logic [WAY_W-1:0] lk_hit_way, lk_victim;
    always_comb begin
        lk_hit     = 1'b0;
        lk_hit_way = '0;
        lk_victim  = '0;
        lk_free    = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w[WAY_W-1:0]] && tag_q[idx][w[WAY_W-1:0]] == req_tag) begin
                lk_hit     = 1'b1;
                lk_hit_way = w[WAY_W-1:0];
            end
        end
        // Scan downwards so the lowest-index invalid way is the one that sticks.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w[WAY_W-1:0]]) begin
                lk_victim = w[WAY_W-1:0];
                lk_free   = 1'b1;
            end
        end
        if (!lk_free) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[idx][w[WAY_W-1:0]] == OLDEST) lk_victim = w[WAY_W-1:0];
            end
        end
    end

    // A write-through write miss is the only completion that leaves the set untouched.
    logic touch;
    assign touch = hit_q || !(is_wr_q && (WRITE_BACK == 0));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (IN_CPU_RD || IN_CPU_WR) state_d = LOOKUP;
            LOOKUP: begin
                if (lk_hit) begin
                    if (!is_wr_q)             state_d = ACK;
                    else if (WRITE_BACK != 0) state_d = WR_HIT;
                    else                      state_d = WT_WR;
                end else if (is_wr_q && (WRITE_BACK == 0)) begin
                    state_d = WT_WR;
                end else if ((WRITE_BACK != 0) && valid_q[idx][lk_victim] && dirty_q[idx][lk_victim]) begin
                    state_d = EVICT;
                end else begin
                    state_d = FILL;
                end
            end
            EVICT:   if (IN_RAM_ACK) state_d = FILL;
            FILL:    if (IN_RAM_ACK) state_d = REFILL;
            REFILL:  state_d = is_wr_q ? WR_HIT : ACK;
            WR_HIT:  state_d = ACK;
            WT_WR:   if (IN_RAM_ACK) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        OUT_ACK       = 1'b0;
        OUT_HIT       = 1'b0;
        OUT_WAY       = way_q;
        OUT_DATA_LOAD = 1'b0;
        OUT_DATA_WR   = 1'b0;
        OUT_RAM_RD    = 1'b0;
        OUT_RAM_WR    = 1'b0;
        OUT_RAM_ADDR  = '0;
        OUT_RAM_SRC   = 1'b0;
        case (state_q)
            EVICT: begin
                OUT_RAM_WR   = 1'b1;
                OUT_RAM_SRC  = 1'b1;
                OUT_RAM_ADDR = {tag_q[idx][way_q], idx};
            end
            FILL: begin
                OUT_RAM_RD   = 1'b1;
                OUT_RAM_ADDR = IN_CPU_ADDR;
            end
            REFILL: OUT_DATA_LOAD = 1'b1;
            WR_HIT: OUT_DATA_WR   = 1'b1;
            WT_WR: begin
                OUT_RAM_WR   = 1'b1;
                OUT_RAM_ADDR = IN_CPU_ADDR;
                OUT_DATA_WR  = hit_q;
            end
            ACK: begin
                OUT_ACK = 1'b1;
                OUT_HIT = hit_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge IN_CLK) begin
        if (IN_RESET) begin
            state_q <= IDLE;
            is_wr_q <= 1'b0;
            hit_q   <= 1'b0;
            way_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s[INDEX_WIDTH-1:0]] <= '0;
                dirty_q[s[INDEX_WIDTH-1:0]] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s[INDEX_WIDTH-1:0]][w[WAY_W-1:0]] <= '0;
                    age_q[s[INDEX_WIDTH-1:0]][w[WAY_W-1:0]] <= w[WAY_W-1:0];
                end
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (IN_CPU_RD || IN_CPU_WR) is_wr_q <= !IN_CPU_RD;
                LOOKUP: begin
                    hit_q <= lk_hit;
                    way_q <= lk_hit ? lk_hit_way : lk_victim;
                end
                REFILL: begin
                    tag_q[idx][way_q]   <= req_tag;
                    valid_q[idx][way_q] <= 1'b1;
                    dirty_q[idx][way_q] <= 1'b0;
                end
                WR_HIT: if (WRITE_BACK != 0) dirty_q[idx][way_q] <= 1'b1;
                ACK: begin
                    if (touch) begin
                        for (int w = 0; w < WAYS; w++) begin
                            if (w[WAY_W-1:0] == way_q)
                                age_q[idx][w[WAY_W-1:0]] <= '0;
                            else if (age_q[idx][w[WAY_W-1:0]] < age_q[idx][way_q])
                                age_q[idx][w[WAY_W-1:0]] <= age_q[idx][w[WAY_W-1:0]] + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_assoc_controller.sv
// Bench for cache_assoc_controller: three instances (2-way write-back, 2-way write-through,
// 4-way write-back) driven by directed and random requests. A transaction-level model with
// per-set recency lists predicts each request's ordered list of observable events.
module tb_cache_assoc_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [3];
    logic        rd [3];
    logic        wr [3];
    logic        rack [3];
    logic [15:0] addr [3];
    logic        ack [3];
    logic        hit [3];
    logic        dload [3];
    logic        dwr [3];
    logic        rrd [3];
    logic        rwr [3];
    logic        rsrc [3];
    logic [15:0] raddr [3];
    logic [0:0]  way0, way1;
    logic [1:0]  way2;

    cache_assoc_controller #(.ADDR_WIDTH(16), .INDEX_WIDTH(4), .WAYS(2), .WRITE_BACK(1)) u_wb2 (
        .IN_CLK(clk), .IN_RESET(rst[0]), .IN_CPU_RD(rd[0]), .IN_CPU_WR(wr[0]), .IN_CPU_ADDR(addr[0]),
        .IN_RAM_ACK(rack[0]), .OUT_ACK(ack[0]), .OUT_HIT(hit[0]), .OUT_WAY(way0),
        .OUT_DATA_LOAD(dload[0]), .OUT_DATA_WR(dwr[0]), .OUT_RAM_RD(rrd[0]), .OUT_RAM_WR(rwr[0]),
        .OUT_RAM_ADDR(raddr[0]), .OUT_RAM_SRC(rsrc[0]));
    cache_assoc_controller #(.ADDR_WIDTH(16), .INDEX_WIDTH(4), .WAYS(2), .WRITE_BACK(0)) u_wt2 (
        .IN_CLK(clk), .IN_RESET(rst[1]), .IN_CPU_RD(rd[1]), .IN_CPU_WR(wr[1]), .IN_CPU_ADDR(addr[1]),
        .IN_RAM_ACK(rack[1]), .OUT_ACK(ack[1]), .OUT_HIT(hit[1]), .OUT_WAY(way1),
        .OUT_DATA_LOAD(dload[1]), .OUT_DATA_WR(dwr[1]), .OUT_RAM_RD(rrd[1]), .OUT_RAM_WR(rwr[1]),
        .OUT_RAM_ADDR(raddr[1]), .OUT_RAM_SRC(rsrc[1]));
    cache_assoc_controller #(.ADDR_WIDTH(16), .INDEX_WIDTH(4), .WAYS(4), .WRITE_BACK(1)) u_wb4 (
        .IN_CLK(clk), .IN_RESET(rst[2]), .IN_CPU_RD(rd[2]), .IN_CPU_WR(wr[2]), .IN_CPU_ADDR(addr[2]),
        .IN_RAM_ACK(rack[2]), .OUT_ACK(ack[2]), .OUT_HIT(hit[2]), .OUT_WAY(way2),
        .OUT_DATA_LOAD(dload[2]), .OUT_DATA_WR(dwr[2]), .OUT_RAM_RD(rrd[2]), .OUT_RAM_WR(rwr[2]),
        .OUT_RAM_ADDR(raddr[2]), .OUT_RAM_SRC(rsrc[2]));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          cfg_ways [3] = '{2, 2, 4};
    int          cfg_wb   [3] = '{1, 0, 1};
    logic [11:0] m_tag   [3][16][4];
    bit          m_valid [3][16][4];
    bit          m_dirty [3][16][4];
    int          m_order [3][16][4];   // per set: ways listed most recently used first

    localparam int EV_EVICT = 0, EV_FILL = 1, EV_LOAD = 2, EV_DWR = 3, EV_WT = 4, EV_ACK = 5;
    int          ev_kind [8];
    logic [15:0] ev_addr [8];
    int          ev_way  [8];
    int          ev_flag [8];
    int          ev_n;

    function automatic void model_reset(input int k);
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 4; w++) begin
                m_valid[k][s][w] = 0;
                m_dirty[k][s][w] = 0;
                m_tag[k][s][w]   = '0;
                m_order[k][s][w] = w;
            end
    endfunction

    function automatic void touch(input int k, input int s, input int w);
        int p = 0;
        for (int i = 0; i < cfg_ways[k]; i++) if (m_order[k][s][i] == w) p = i;
        for (int i = p; i > 0; i--) m_order[k][s][i] = m_order[k][s][i-1];
        m_order[k][s][0] = w;
    endfunction

    function automatic void add_ev(input int kind, input logic [15:0] a, input int w, input int f);
        ev_kind[ev_n] = kind;
        ev_addr[ev_n] = a;
        ev_way[ev_n]  = w;
        ev_flag[ev_n] = f;
        ev_n++;
    endfunction

    function automatic void plan(input int k, input bit is_wr, input logic [15:0] a);
        int s, hw, v;
        logic [11:0] t;
        bit h;
        s = int'(a[3:0]);
        t = a[15:4];
        h = 0; hw = 0; v = -1; ev_n = 0;
        for (int w = 0; w < cfg_ways[k]; w++)
            if (m_valid[k][s][w] && m_tag[k][s][w] == t) begin h = 1; hw = w; end
        if (h) begin
            if (!is_wr) add_ev(EV_ACK, 16'h0, 0, 1);
            else if (cfg_wb[k] != 0) begin
                add_ev(EV_DWR, 16'h0, hw, 0);
                add_ev(EV_ACK, 16'h0, 0, 1);
                m_dirty[k][s][hw] = 1;
            end else begin
                add_ev(EV_WT, a, hw, 1);
                add_ev(EV_ACK, 16'h0, 0, 1);
            end
            touch(k, s, hw);
        end else if (is_wr && cfg_wb[k] == 0) begin
            add_ev(EV_WT, a, 0, 0);
            add_ev(EV_ACK, 16'h0, 0, 0);
        end else begin
            for (int w = cfg_ways[k] - 1; w >= 0; w--) if (!m_valid[k][s][w]) v = w;
            if (v < 0) v = m_order[k][s][cfg_ways[k] - 1];
            if (cfg_wb[k] != 0 && m_valid[k][s][v] && m_dirty[k][s][v])
                add_ev(EV_EVICT, {m_tag[k][s][v], a[3:0]}, v, 0);
            add_ev(EV_FILL, a, v, 0);
            add_ev(EV_LOAD, 16'h0, v, 0);
            if (is_wr) add_ev(EV_DWR, 16'h0, v, 0);
            add_ev(EV_ACK, 16'h0, 0, 0);
            m_tag[k][s][v]   = t;
            m_valid[k][s][v] = 1;
            m_dirty[k][s][v] = is_wr;
            touch(k, s, v);
        end
    endfunction

    // ---------------- DUT access ----------------
    int o_ack, o_hit, o_way, o_dload, o_dwr, o_rrd, o_rwr, o_rsrc, o_raddr;
    int last_hit, last_ack_n, n_strobe;
    bit abort_seen;

    task automatic sample(input int k);
        o_ack = int'(ack[k]);  o_hit = int'(hit[k]);   o_dload = int'(dload[k]);
        o_dwr = int'(dwr[k]);  o_rrd = int'(rrd[k]);   o_rwr = int'(rwr[k]);
        o_rsrc = int'(rsrc[k]); o_raddr = int'(raddr[k]);
        case (k)
            0:       o_way = int'(way0);
            1:       o_way = int'(way1);
            default: o_way = int'(way2);
        endcase
    endtask

    task automatic do_reset(input int k);
        rst[k] = 1'b1; rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = 16'h0; rack[k] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sample(k);
        chk("rst_ack", o_ack, 0);     chk("rst_hit", o_hit, 0);   chk("rst_way", o_way, 0);
        chk("rst_load", o_dload, 0);  chk("rst_dwr", o_dwr, 0);   chk("rst_ram_rd", o_rrd, 0);
        chk("rst_ram_wr", o_rwr, 0);  chk("rst_src", o_rsrc, 0);  chk("rst_ram_addr", o_raddr, 0);
        rst[k] = 1'b0;
        model_reset(k);
    endtask

    // One CPU request: drive it, then compare every cycle's outputs with the planned events.
    task automatic run_req(input int k, input bit rd_in, input bit wr_in, input logic [15:0] a,
                           input bit rst_at_evict);
        int ei, obs;
        bit done, broken;
        plan(k, !rd_in && wr_in, a);
        rd[k] = rd_in; wr[k] = wr_in; addr[k] = a; rack[k] = 1'b0;
        ei = 0; done = 0; broken = 0; n_strobe = 0;
        for (int n = 1; n <= 200 && !done; n++) begin
            @(negedge clk);
            sample(k);
            rack[k] = 1'b0;
            obs = -1;
            if (o_rwr != 0 && o_rsrc != 0) obs = EV_EVICT;
            else if (o_rwr != 0)           obs = EV_WT;
            else if (o_rrd != 0)           obs = EV_FILL;
            else if (o_dload != 0)         obs = EV_LOAD;
            else if (o_dwr != 0)           obs = EV_DWR;
            else if (o_ack != 0)           obs = EV_ACK;
            if (obs < 0) begin
                // Stray RAM acks outside RAM states must be ignored.
                if ($urandom_range(0, 3) == 0) rack[k] = 1'b1;
            end else begin
                chk("one_action", o_rrd + o_rwr + o_dload + o_ack + ((o_dwr != 0 && o_rwr == 0) ? 1 : 0), 1);
                if (ei >= ev_n) begin
                    chk("extra_event", obs, -1);
                    broken = 1; done = 1;
                end else if (obs != ev_kind[ei]) begin
                    chk("event_kind", obs, ev_kind[ei]);
                    broken = 1; done = 1;
                end else begin
                    case (obs)
                        EV_EVICT, EV_FILL, EV_WT: begin
                            n_strobe++;
                            chk("ram_addr", o_raddr, int'(ev_addr[ei]));
                            if (obs == EV_EVICT) chk("evict_way", o_way, ev_way[ei]);
                            if (obs == EV_WT) begin
                                chk("wt_data_wr", o_dwr, ev_flag[ei]);
                                if (ev_flag[ei] != 0) chk("wt_way", o_way, ev_way[ei]);
                            end
                            if (obs == EV_EVICT && rst_at_evict) begin
                                rst[k] = 1'b1;
                                @(negedge clk);
                                sample(k);
                                chk("abort_ram_rd", o_rrd, 0);  chk("abort_ram_wr", o_rwr, 0);
                                chk("abort_ack", o_ack, 0);     chk("abort_load", o_dload, 0);
                                chk("abort_dwr", o_dwr, 0);     chk("abort_way", o_way, 0);
                                rst[k] = 1'b0;
                                rd[k] = 1'b0; wr[k] = 1'b0;
                                model_reset(k);
                                abort_seen = 1;
                                done = 1;
                            end else if ($urandom_range(0, 2) == 0) begin
                                rack[k] = 1'b1;
                                ei++;
                            end
                        end
                        EV_LOAD: begin chk("load_way", o_way, ev_way[ei]); ei++; end
                        EV_DWR:  begin chk("dwr_way", o_way, ev_way[ei]);  ei++; end
                        default: begin
                            chk("ack_hit", o_hit, ev_flag[ei]);
                            if (n_strobe == 0) chk("ack_latency", n, ei + 2);
                            last_hit = o_hit;
                            last_ack_n = n;
                            ei++;
                            rd[k] = 1'b0; wr[k] = 1'b0;
                            done = 1;
                        end
                    endcase
                end
            end
        end
        if (!done) chk("timeout", 1, 0);
        rd[k] = 1'b0; wr[k] = 1'b0; rack[k] = 1'b0;
        if (!done || broken) do_reset(k);
        else begin
            @(negedge clk);
            sample(k);
            chk("idle_no_ack", o_ack, 0);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; rd[k] = 1'b0; wr[k] = 1'b0; rack[k] = 1'b0; addr[k] = 16'h0;
        end
        last_hit = 0; last_ack_n = 0; n_strobe = 0; abort_seen = 0;
        for (int k = 0; k < 3; k++) do_reset(k);

        // 2-way write-back: cold miss, then hit.
        run_req(0, 1, 0, 16'h0010, 0);
        chk("m1_fill_kind", ev_kind[0], EV_FILL);
        chk("m1_fill_addr", int'(ev_addr[0]), 'h0010);
        chk("m1_load_way", ev_way[1], 0);
        chk("t1_hit", last_hit, 0);
        run_req(0, 1, 0, 16'h0010, 0);
        chk("t2_hit", last_hit, 1);
        chk("t2_latency", last_ack_n, 2);
        chk("t2_no_ram", n_strobe, 0);

        // Dirty way 0 becomes the LRU victim of a conflicting read.
        run_req(0, 0, 1, 16'h0010, 0);
        chk("t3_wr_latency", last_ack_n, 3);
        run_req(0, 1, 0, 16'h0020, 0);
        run_req(0, 1, 0, 16'h0030, 0);
        chk("m3_evict_kind", ev_kind[0], EV_EVICT);
        chk("m3_evict_addr", int'(ev_addr[0]), 'h0010);
        chk("m3_evict_way", ev_way[0], 0);
        chk("m3_fill_addr", int'(ev_addr[1]), 'h0030);
        chk("m3_load_way", ev_way[2], 0);

        // Write-through: write miss does not allocate.
        run_req(1, 0, 1, 16'h0040, 0);
        chk("m4_wt_kind", ev_kind[0], EV_WT);
        chk("m4_wt_dwr", ev_flag[0], 0);
        run_req(1, 1, 0, 16'h0040, 0);
        chk("t4_rd_miss", last_hit, 0);

        // 4-way: fill set 3, touch ways 0..2, next miss must replace way 3.
        for (int i = 0; i < 4; i++) run_req(2, 1, 0, 16'(i * 16 + 3), 0);
        for (int i = 0; i < 3; i++) run_req(2, 1, 0, 16'(i * 16 + 3), 0);
        chk("t5_touch_hit", last_hit, 1);
        run_req(2, 1, 0, 16'h0043, 0);
        chk("m5_no_evict", ev_kind[0], EV_FILL);
        chk("m5_victim", ev_way[1], 3);
        run_req(2, 1, 0, 16'h0033, 0);
        chk("t5_evicted_miss", last_hit, 0);

        // Reset in the middle of an eviction.
        run_req(0, 0, 1, 16'h0030, 0);
        run_req(0, 0, 1, 16'h0020, 0);
        run_req(0, 1, 0, 16'h0050, 1);
        chk("t6_evict_reached", int'(abort_seen), 1);
        chk("m6_evict_addr", int'(ev_addr[0]), 'h0030);
        run_req(0, 1, 0, 16'h0020, 0);
        chk("t6_miss_after_reset", last_hit, 0);

        // Random traffic on every configuration; a few sets and tags force conflicts.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 150; i++) begin
                int op, s, t;
                op = $urandom_range(0, 3);
                s  = $urandom_range(0, 2) * 5;
                t  = $urandom_range(0, 5);
                run_req(k, op != 2, op >= 2, 16'(t * 16 + s), 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
